// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: datapath widths,
// writeback source encodings and architecturally special register numbers.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_PC  = 2'b10,
        WB_SEL_RSV = 2'b11
    } wbSel_t;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_mux.sv
// Writeback source select shared by the pipelined and multicycle datapaths.
// The reserved encoding and any unknown select fall back to the ALU result.
module wb_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] memData,
    input  logic [DATA_W-1:0] pcPlus4,
    output logic [DATA_W-1:0] wbValue
);

    // Select the value to be written back.
    always_comb begin
        wbValue = aluResult;
        case (sel)
            WB_SEL_ALU: wbValue = aluResult;
            WB_SEL_MEM: wbValue = memData;
            WB_SEL_PC:  wbValue = pcPlus4;
            WB_SEL_RSV: wbValue = aluResult;
            default:    wbValue = aluResult;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, writes the 32-entry register
// file and serves two ID-stage read ports with same-cycle write-through bypass.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_wb,
    input  logic [1:0]        mem_to_reg_wb,
    input  logic [REG_AW-1:0] reg_dst_wb,
    input  logic [DATA_W-1:0] memory_data_wb,
    input  logic [DATA_W-1:0] alu_result_wb,
    input  logic [DATA_W-1:0] adder_pc_out_wb,
    input  logic [REG_AW-1:0] read_reg1,
    input  logic [REG_AW-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] write_data_wb,
    output logic              write_en_wb
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] regFile [DEPTH];
    logic [DATA_W-1:0] wbValue;
    logic              writeEn;

    wb_mux #(.DATA_W(DATA_W)) wbMux (
        .sel       (mem_to_reg_wb),
        .aluResult (alu_result_wb),
        .memData   (memory_data_wb),
        .pcPlus4   (adder_pc_out_wb),
        .wbValue   (wbValue)
    );

    // Writes to $0 and writes during reset are suppressed at the source so
    // forwarding logic downstream never sees them either.
    always_comb begin
        writeEn = 1'b0;
        if (reg_write_wb && (reg_dst_wb != REG_ZERO) && !rst) begin
            writeEn = 1'b1;
        end else begin
            writeEn = 1'b0;
        end
    end

    // Register array update; reset clears every entry and overrides any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile[i] <= {DATA_W{1'b0}};
            end
        end else if (writeEn) begin
            regFile[reg_dst_wb] <= wbValue;
        end
    end

    // Read port 1 with $0 forced to zero and write-through bypass.
    always_comb begin
        read_data1 = {DATA_W{1'b0}};
        if (read_reg1 == REG_ZERO) begin
            read_data1 = {DATA_W{1'b0}};
        end else if (writeEn && (read_reg1 == reg_dst_wb)) begin
            read_data1 = wbValue;
        end else begin
            read_data1 = regFile[read_reg1];
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        read_data2 = {DATA_W{1'b0}};
        if (read_reg2 == REG_ZERO) begin
            read_data2 = {DATA_W{1'b0}};
        end else if (writeEn && (read_reg2 == reg_dst_wb)) begin
            read_data2 = wbValue;
        end else begin
            read_data2 = regFile[read_reg2];
        end
    end

    assign write_data_wb = wbValue;
    assign write_en_wb   = writeEn;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, source select, $0 guard,
// bypass, disabled writes and reset colliding with a write.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        reg_write_wb;
    logic [1:0]  mem_to_reg_wb;
    logic [4:0]  reg_dst_wb;
    logic [31:0] memory_data_wb;
    logic [31:0] alu_result_wb;
    logic [31:0] adder_pc_out_wb;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] write_data_wb;
    logic        write_en_wb;

    int passCount = 0;
    int checkCount = 0;

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .reg_write_wb    (reg_write_wb),
        .mem_to_reg_wb   (mem_to_reg_wb),
        .reg_dst_wb      (reg_dst_wb),
        .memory_data_wb  (memory_data_wb),
        .alu_result_wb   (alu_result_wb),
        .adder_pc_out_wb (adder_pc_out_wb),
        .read_reg1       (read_reg1),
        .read_reg2       (read_reg2),
        .read_data1      (read_data1),
        .read_data2      (read_data2),
        .write_data_wb   (write_data_wb),
        .write_en_wb     (write_en_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        reg_write_wb = 1'b0;
        mem_to_reg_wb = 2'b00;
        reg_dst_wb = 5'd0;
        memory_data_wb = 32'h0;
        alu_result_wb = 32'h0;
        adder_pc_out_wb = 32'h0;
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        tick();
        read_reg1 = 5'd5;
        read_reg2 = 5'd31;
        settle();
        check("reset_rd1", read_data1, 32'h0);
        check("reset_rd2", read_data2, 32'h0);
        check("reset_wen", {31'h0, write_en_wb}, 32'h0);

        // Preload r5 and r31, confirm, then reset them away.
        rst = 1'b0;
        reg_write_wb = 1'b1;
        reg_dst_wb = 5'd5;
        alu_result_wb = 32'h0000_1234;
        tick();
        reg_dst_wb = 5'd31;
        alu_result_wb = 32'hFFFF_FFFF;
        tick();
        reg_write_wb = 1'b0;
        settle();
        check("preload_r5", read_data1, 32'h0000_1234);
        check("preload_r31", read_data2, 32'hFFFF_FFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst_clear_r5", read_data1, 32'h0);
        check("rst_clear_r31", read_data2, 32'h0);

        // Writeback source select into r8.
        reg_dst_wb = 5'd8;
        alu_result_wb = 32'hA;
        memory_data_wb = 32'hB;
        adder_pc_out_wb = 32'hC;
        read_reg1 = 5'd8;
        read_reg2 = 5'd0;
        reg_write_wb = 1'b1;
        mem_to_reg_wb = 2'b00;
        settle();
        check("sel00_wdata", write_data_wb, 32'hA);
        tick();
        reg_write_wb = 1'b0;
        settle();
        check("sel00_r8", read_data1, 32'hA);
        reg_write_wb = 1'b1;
        mem_to_reg_wb = 2'b01;
        settle();
        check("sel01_wdata", write_data_wb, 32'hB);
        tick();
        reg_write_wb = 1'b0;
        settle();
        check("sel01_r8", read_data1, 32'hB);
        reg_write_wb = 1'b1;
        mem_to_reg_wb = 2'b10;
        settle();
        check("sel10_wdata", write_data_wb, 32'hC);
        tick();
        reg_write_wb = 1'b0;
        settle();
        check("sel10_r8", read_data1, 32'hC);
        reg_write_wb = 1'b1;
        mem_to_reg_wb = 2'b11;
        settle();
        check("sel11_wdata", write_data_wb, 32'hA);
        tick();
        reg_write_wb = 1'b0;
        settle();
        check("sel11_r8", read_data1, 32'hA);

        // $0 guard.
        mem_to_reg_wb = 2'b00;
        reg_write_wb = 1'b1;
        reg_dst_wb = 5'd0;
        alu_result_wb = 32'hDEAD_BEEF;
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        settle();
        check("r0_wen", {31'h0, write_en_wb}, 32'h0);
        check("r0_wdata", write_data_wb, 32'hDEAD_BEEF);
        check("r0_same", read_data1, 32'h0);
        tick();
        reg_write_wb = 1'b0;
        settle();
        check("r0_next", read_data1, 32'h0);

        // Write-through bypass on both ports.
        reg_write_wb = 1'b1;
        reg_dst_wb = 5'd9;
        alu_result_wb = 32'h1111;
        tick();
        reg_write_wb = 1'b0;
        read_reg1 = 5'd9;
        read_reg2 = 5'd9;
        settle();
        check("r9_hold", read_data1, 32'h1111);
        reg_write_wb = 1'b1;
        alu_result_wb = 32'h2222;
        settle();
        check("byp_rd1", read_data1, 32'h2222);
        check("byp_rd2", read_data2, 32'h2222);
        tick();
        reg_write_wb = 1'b0;
        settle();
        check("byp_after_rd1", read_data1, 32'h2222);
        check("byp_after_rd2", read_data2, 32'h2222);

        // Disabled write: no bypass, no update, even with an unknown select.
        alu_result_wb = 32'h3333;
        settle();
        check("dis_wen", {31'h0, write_en_wb}, 32'h0);
        check("dis_rd1", read_data1, 32'h2222);
        mem_to_reg_wb = 2'bxx;
        tick();
        check("dis_after", read_data1, 32'h2222);
        mem_to_reg_wb = 2'b00;

        // Reset colliding with a write to r12.
        reg_write_wb = 1'b1;
        reg_dst_wb = 5'd12;
        alu_result_wb = 32'h7777;
        read_reg1 = 5'd12;
        tick();
        alu_result_wb = 32'h5555;
        rst = 1'b1;
        settle();
        check("rstw_wen", {31'h0, write_en_wb}, 32'h0);
        check("rstw_wdata", write_data_wb, 32'h5555);
        check("rstw_nobyp", read_data1, 32'h7777);
        tick();
        rst = 1'b0;
        reg_write_wb = 1'b0;
        settle();
        check("rstw_r12", read_data1, 32'h0);
        check("rstw_r9", read_data2, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
